imem_program_loader: RTL and testbench

Instruction encoder and loader for the single-cycle processor. It accepts symbolic instruction fields over a valid/ready stream and packs each beat into a 32-bit instruction word. It uses the same bit layout the controller's decoder consumes: Cond, Op, Funct, Rd, plus MulOp for multiply. It writes the words sequentially into instruction memory and holds the core in reset until a complete program has been loaded.

---
 rtl/imem_program_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_program_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Packs symbolic instruction fields into 32-bit words and writes them into instruction memory.
// The core is held in reset until a full program has been loaded.
module imem_program_loader #(
   parameter int AW    = 6,
   parameter int DEPTH = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          f_valid,
   output logic          f_ready,
   input  logic          f_last,
   input  logic [1:0]    f_cls,
   input  logic [3:0]    f_cond,
   input  logic [5:0]    f_funct,
   input  logic [3:0]    f_ra,
   input  logic [3:0]    f_rb,
   input  logic [23:0]   f_imm,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          core_hold,
   output logic          done,
   output logic          err_illegal,
   output logic          err_ovf,
   output logic [AW:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_RUN,
      S_ERROR
   } state_t;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [AW:0]   words_q, words_d;
   logic          err_ill_q, err_ill_d;
   logic          err_ovf_q, err_ovf_d;
   logic          core_hold_q, core_hold_d;
   logic          done_q, done_d;

   logic [31:0]   enc_word;
   logic          beat_illegal;
   logic          ready;
   logic          hs;

   always_comb begin
      enc_word = 32'h0;
      unique case (f_cls)
         2'b00:   enc_word = {f_cond, 2'b00, f_funct, f_ra, f_rb, f_imm[11:0]};
         2'b01:   enc_word = {f_cond, 2'b01, f_funct, f_ra, f_rb, f_imm[11:0]};
         2'b10:   enc_word = {f_cond, 2'b10, 1'b1, f_funct[0], f_imm};
         default: enc_word = {f_cond, 6'b000000, f_funct[1:0], f_ra, f_rb,
                              f_imm[3:0], 4'b1001, f_imm[7:4]};
      endcase
      beat_illegal = (f_cls == 2'b11) && (f_funct[5:2] != 4'b0000);
   end

   // Stop accepting once the words already committed or in flight fill the memory.
   assign ready = (state_q == S_LOAD) && !start &&
                  ((words_q + (AW+1)'(we_q)) < DEPTH_W);
   assign hs    = f_valid && ready;

   always_comb begin
      state_d   = state_q;
      we_d      = 1'b0;
      addr_d    = we_q ? addr_q + AW'(1) : addr_q;
      words_d   = words_q + (AW+1)'(we_q);
      wdata_d   = wdata_q;
      err_ill_d = err_ill_q;
      err_ovf_d = err_ovf_q;
      unique case (state_q)
         S_IDLE, S_RUN, S_ERROR: begin
            if (start) begin
               state_d   = S_LOAD;
               addr_d    = '0;
               words_d   = '0;
               err_ill_d = 1'b0;
               err_ovf_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (start) begin
               addr_d  = '0;
               words_d = '0;
            end else begin
               if (hs) begin
                  if (beat_illegal) begin
                     err_ill_d = 1'b1;
                  end else begin
                     we_d    = 1'b1;
                     wdata_d = enc_word;
                  end
               end
               if (hs && f_last) begin
                  state_d = S_DRAIN;
               end else if (we_q && (words_q + (AW+1)'(1) == DEPTH_W)) begin
                  state_d   = S_ERROR;
                  err_ovf_d = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            // The single in-flight write always retires during this cycle.
            if (start) begin
               state_d = S_LOAD;
               addr_d  = '0;
               words_d = '0;
            end else begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase
      core_hold_d = (state_d != S_RUN);
      done_d      = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         words_q     <= '0;
         err_ill_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
         core_hold_q <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         words_q     <= words_d;
         err_ill_q   <= err_ill_d;
         err_ovf_q   <= err_ovf_d;
         core_hold_q <= core_hold_d;
         done_q      <= done_d;
      end
   end

   assign f_ready      = ready;
   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign core_hold    = core_hold_q;
   assign done         = done_q;
   assign err_illegal  = err_ill_q;
   assign err_ovf      = err_ovf_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Randomized self-checking bench for imem_program_loader against a program-level reference model.
module tb_imem_program_loader;

   localparam int AW    = 3;
   localparam int DEPTH = 4;

   typedef struct {
      logic [1:0]  cls;
      logic [3:0]  cond;
      logic [5:0]  funct;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [23:0] imm;
      logic        last;
   } beat_t;

   typedef struct {
      int unsigned addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          f_valid;
   logic          f_ready;
   logic          f_last;
   logic [1:0]    f_cls;
   logic [3:0]    f_cond;
   logic [5:0]    f_funct;
   logic [3:0]    f_ra;
   logic [3:0]    f_rb;
   logic [23:0]   f_imm;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_hold;
   logic          done;
   logic          err_illegal;
   logic          err_ovf;
   logic [AW:0]   words_loaded;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   wr_t         got_q[$];
   beat_t       prog_q[$];
   logic [31:0] exp_q[$];
   bit          exp_ill;
   bit          exp_ovf;
   int          exp_nsend;
   int          prog_id = 0;

   imem_program_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start),
      .f_valid(f_valid), .f_ready(f_ready), .f_last(f_last),
      .f_cls(f_cls), .f_cond(f_cond), .f_funct(f_funct),
      .f_ra(f_ra), .f_rb(f_rb), .f_imm(f_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_hold(core_hold), .done(done),
      .err_illegal(err_illegal), .err_ovf(err_ovf), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we === 1'b1) got_q.push_back('{int'(imem_addr), imem_wdata, cyc});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference encoding built from the field layout with shifts and masks.
   function automatic logic [31:0] encode(input beat_t b);
      logic [31:0] w;
      w = 32'(b.cond) << 28;
      case (b.cls)
         2'd0, 2'd1: w = w | (32'(b.cls) << 26) | (32'(b.funct) << 20) | (32'(b.ra) << 16)
                         | (32'(b.rb) << 12) | (32'(b.imm) & 32'hFFF);
         2'd2:       w = w | (32'd2 << 26) | (32'd1 << 25) | ((32'(b.funct) & 32'd1) << 24)
                         | 32'(b.imm);
         default:    w = w | ((32'(b.funct) & 32'd3) << 20) | (32'(b.ra) << 16)
                         | (32'(b.rb) << 12) | ((32'(b.imm) & 32'hF) << 8) | (32'd9 << 4)
                         | ((32'(b.imm) >> 4) & 32'hF);
      endcase
      return w;
   endfunction

   function automatic bit is_illegal(input beat_t b);
      return (b.cls == 2'd3) && ((b.funct >> 2) != 6'd0);
   endfunction

   function automatic beat_t mk(input logic [1:0] cls, input logic [3:0] cond,
                                input logic [5:0] funct, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [23:0] imm, input logic last);
      beat_t b;
      b.cls = cls; b.cond = cond; b.funct = funct; b.ra = ra; b.rb = rb; b.imm = imm; b.last = last;
      return b;
   endfunction

   function automatic beat_t rand_beat(input bit allow_ill);
      beat_t b;
      b.cls   = 2'($urandom);
      b.cond  = 4'($urandom);
      b.funct = 6'($urandom);
      b.ra    = 4'($urandom);
      b.rb    = 4'($urandom);
      b.imm   = 24'($urandom);
      b.last  = 1'b0;
      if (b.cls == 2'd3 && !(allow_ill && ($urandom_range(0, 3) == 0))) b.funct[5:2] = 4'd0;
      return b;
   endfunction

   // Program-level model: which words land, which flags end up set, how many beats are taken.
   task automatic model_program();
      exp_q.delete();
      exp_ill   = 1'b0;
      exp_ovf   = 1'b0;
      exp_nsend = 0;
      foreach (prog_q[i]) begin
         exp_nsend++;
         if (is_illegal(prog_q[i])) exp_ill = 1'b1;
         else exp_q.push_back(encode(prog_q[i]));
         if (prog_q[i].last) break;
         if (exp_q.size() == DEPTH) begin
            exp_ovf = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_start(input bit expect_clear);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_wl", 32'(words_loaded), 32'd0);
      check("start_addr", 32'(imem_addr), 32'd0);
      check("start_hold", 32'(core_hold), 32'd1);
      if (expect_clear) begin
         check("start_ill_clr", 32'(err_illegal), 32'd0);
         check("start_ovf_clr", 32'(err_ovf), 32'd0);
      end
   endtask

   task automatic send_beat(input beat_t b, input bit gaps, output bit ok, output bit first_rdy);
      bit r;
      ok = 1'b0;
      first_rdy = 1'b0;
      if (gaps) begin
         f_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      f_cls = b.cls; f_cond = b.cond; f_funct = b.funct;
      f_ra = b.ra; f_rb = b.rb; f_imm = b.imm; f_last = b.last;
      f_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         r = f_ready;
         if (k == 0) first_rdy = r;
         @(posedge clk); #1;
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      f_valid = 1'b0;
      f_last  = 1'b0;
   endtask

   task automatic finish_and_check(input bit check_consec);
      @(negedge clk);
      check("drain_done", 32'(done), 32'd0);
      @(negedge clk);
      if (exp_ovf) begin
         check("ovf_hold", 32'(core_hold), 32'd1);
         check("ovf_ready", 32'(f_ready), 32'd0);
         check("ovf_done", 32'(done), 32'd0);
      end else begin
         check("run_done", 32'(done), 32'd1);
         check("run_hold", 32'(core_hold), 32'd0);
      end
      check("err_ovf", 32'(err_ovf), 32'(exp_ovf));
      check("err_ill", 32'(err_illegal), 32'(exp_ill));
      check("words_loaded", 32'(words_loaded), 32'(exp_q.size()));
      check("n_writes", 32'(got_q.size()), 32'(exp_q.size()));
      foreach (got_q[i]) begin
         if (i < exp_q.size()) begin
            check($sformatf("addr%0d", i), 32'(got_q[i].addr), 32'(i));
            check($sformatf("data%0d", i), got_q[i].data, exp_q[i]);
            if (check_consec && i > 0)
               check($sformatf("consec%0d", i), 32'(got_q[i].cyc - got_q[i-1].cyc), 32'd1);
         end
      end
      $display("program %0d: beats=%0d writes=%0d ill=%0d ovf=%0d errors_so_far=%0d",
               prog_id, exp_nsend, got_q.size(), err_illegal, err_ovf, n_errors);
      prog_id++;
   endtask

   task automatic run_program(input bit gaps, input bit check_consec);
      bit ok, rdy;
      model_program();
      got_q.delete();
      do_start(1'b1);
      for (int i = 0; i < exp_nsend; i++) begin
         send_beat(prog_q[i], gaps, ok, rdy);
         if (!ok) begin
            check("hs_timeout", 32'd0, 32'd1);
            break;
         end
         if (!gaps) check($sformatf("ready_b2b%0d", i), 32'(rdy), 32'd1);
      end
      finish_and_check(check_consec);
   endtask

   initial begin
      bit ok, rdy;
      beat_t b;
      int nleg;
      reset = 1'b0; start = 1'b0; f_valid = 1'b0; f_last = 1'b0;
      f_cls = '0; f_cond = '0; f_funct = '0; f_ra = '0; f_rb = '0; f_imm = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_hold", 32'(core_hold), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready", 32'(f_ready), 32'd0);
      check("rst_wl", 32'(words_loaded), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", 32'(f_ready), 32'd0);

      // Single data-processing beat.
      prog_q = '{mk(2'd0, 4'hE, 6'b101000, 4'd1, 4'd2, 24'h000005, 1'b1)};
      check("enc_dp_model", encode(prog_q[0]), 32'hE2812005);
      run_program(1'b0, 1'b0);

      // Back-to-back branch then memory.
      prog_q = '{mk(2'd2, 4'hE, 6'd0, 4'd0, 4'd0, 24'hFFFFFE, 1'b0),
                 mk(2'd1, 4'hE, 6'b011001, 4'd0, 4'd3, 24'h000004, 1'b1)};
      run_program(1'b0, 1'b1);

      // Multiply.
      prog_q = '{mk(2'd3, 4'hE, 6'd0, 4'd4, 4'd0, 24'h000033, 1'b1)};
      run_program(1'b0, 1'b0);

      // Illegal multiply between two legal beats.
      prog_q = '{mk(2'd0, 4'h1, 6'd3, 4'd5, 4'd6, 24'h000ABC, 1'b0),
                 mk(2'd3, 4'hE, 6'b000100, 4'd1, 4'd2, 24'h000012, 1'b0),
                 mk(2'd1, 4'h0, 6'd9, 4'd7, 4'd8, 24'h000123, 1'b1)};
      run_program(1'b0, 1'b0);

      // DEPTH beats without last, then restart clears flags inside do_start.
      prog_q = '{mk(2'd0, 4'h2, 6'd1, 4'd1, 4'd1, 24'h1, 1'b0),
                 mk(2'd0, 4'h3, 6'd2, 4'd2, 4'd2, 24'h2, 1'b0),
                 mk(2'd1, 4'h4, 6'd3, 4'd3, 4'd3, 24'h3, 1'b0),
                 mk(2'd2, 4'h5, 6'd1, 4'd4, 4'd4, 24'h4, 1'b0)};
      run_program(1'b0, 1'b0);

      // Restart inside LOAD keeps sticky errors; start beats a simultaneous beat.
      got_q.delete();
      do_start(1'b1);
      send_beat(mk(2'd3, 4'h0, 6'b010000, 4'd0, 4'd0, 24'h0, 1'b0), 1'b0, ok, rdy);
      send_beat(mk(2'd0, 4'h7, 6'd7, 4'd7, 4'd7, 24'h777, 1'b0), 1'b0, ok, rdy);
      start = 1'b1;
      f_valid = 1'b1; f_cls = 2'd0; f_last = 1'b1;
      @(negedge clk);
      check("start_blocks_ready", 32'(f_ready), 32'd0);
      @(posedge clk); #1;
      start = 1'b0; f_valid = 1'b0; f_last = 1'b0;
      got_q.delete();
      check("restart_wl", 32'(words_loaded), 32'd0);
      check("restart_addr", 32'(imem_addr), 32'd0);
      check("restart_ill_kept", 32'(err_illegal), 32'd1);
      @(negedge clk);
      check("restart_no_we", 32'(imem_we), 32'd0);
      @(posedge clk); #1;
      b = mk(2'd1, 4'h9, 6'd25, 4'd1, 4'd2, 24'h0456, 1'b1);
      prog_q = '{b};
      model_program();
      exp_ill = 1'b1;
      send_beat(b, 1'b0, ok, rdy);
      check("restart_hs", 32'(ok), 32'd1);
      finish_and_check(1'b0);

      // Randomized programs.
      for (int p = 0; p < 30; p++) begin
         prog_q.delete();
         if ($urandom_range(0, 3) == 0) begin
            nleg = 0;
            for (int k = 0; k < 40 && nleg < DEPTH; k++) begin
               b = rand_beat(1'b1);
               if (!is_illegal(b)) nleg++;
               prog_q.push_back(b);
            end
         end else begin
            for (int k = 0, n = $urandom_range(1, DEPTH); k < n; k++) begin
               b = rand_beat(1'b1);
               b.last = (k == n - 1);
               prog_q.push_back(b);
            end
         end
         run_program(1'($urandom), 1'b0);
      end

      // Asynchronous reset while a write is pending.
      got_q.delete();
      do_start(1'b1);
      send_beat(mk(2'd0, 4'hA, 6'd5, 4'd3, 4'd4, 24'h0BB, 1'b0), 1'b0, ok, rdy);
      check("pre_rst_we", 32'(imem_we), 32'd1);
      reset = 1'b0;
      #1;
      check("arst_we", 32'(imem_we), 32'd0);
      check("arst_addr", 32'(imem_addr), 32'd0);
      check("arst_wdata", imem_wdata, 32'd0);
      check("arst_hold", 32'(core_hold), 32'd1);
      check("arst_done", 32'(done), 32'd0);
      check("arst_ready", 32'(f_ready), 32'd0);
      check("arst_wl", 32'(words_loaded), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", 32'(f_ready), 32'd0);
      prog_q = '{mk(2'd2, 4'h3, 6'd1, 4'd0, 4'd0, 24'h123456, 1'b1)};
      run_program(1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
